test_pattern_gen_axis: RTL and testbench

Parametrised AXI4-Stream video test-pattern source for the JPEG encoder datapath.
- Generates WIDTH x HEIGHT frames of NUM_CH=3 channel pixels (R in MSBs, then G, then B) in one of five selectable patterns.
- Has full tready backpressure without a frame buffer, single-shot or continuous frame mode, and frame status outputs.
- Drives the encoder input stream in simulation and on FPGA bring-up.

---
 rtl/tpg_pkg.sv | 40 ++++
 rtl/test_pattern_gen_axis_pixel_calc.sv | 44 ++++
 rtl/test_pattern_gen_axis.sv | 176 +++++++++++++++++
 tb/tb_test_pattern_gen_axis.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpg_pkg.sv
// Shared types and helpers for the AXI4-Stream test-pattern generator.
package tpg_pkg;

  localparam int unsigned MAX_CH_BITWIDTH  = 16;
  localparam int unsigned MAX_PIX_BITWIDTH = 3 * MAX_CH_BITWIDTH;

  typedef enum logic [2:0] {
    MODE_QUAD  = 3'd0,
    MODE_BARS  = 3'd1,
    MODE_GRAD  = 3'd2,
    MODE_CHECK = 3'd3,
    MODE_SOLID = 3'd4
  } mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Colour codes: bit 2 = R, bit 1 = G, bit 0 = B at full scale
  localparam logic [2:0] CODE_BLACK = 3'b000;
  localparam logic [2:0] CODE_BLUE  = 3'b001;
  localparam logic [2:0] CODE_GREEN = 3'b010;
  localparam logic [2:0] CODE_RED   = 3'b100;
  localparam logic [2:0] CODE_WHITE = 3'b111;

  // Expand a 3-bit colour code to a {R,G,B} pixel of ch_bitwidth bits per channel
  function automatic logic [MAX_PIX_BITWIDTH-1:0] code_to_pixel(input logic [2:0] code,
                                                                input int unsigned ch_bitwidth);
    logic [MAX_PIX_BITWIDTH-1:0] full;
    logic [MAX_PIX_BITWIDTH-1:0] pix;
    full = (MAX_PIX_BITWIDTH'(1) << ch_bitwidth) - MAX_PIX_BITWIDTH'(1);
    pix  = '0;
    if (code[2]) pix = pix | (full << (2 * ch_bitwidth));
    if (code[1]) pix = pix | (full << ch_bitwidth);
    if (code[0]) pix = pix | full;
    return pix;
  endfunction

endpackage

// File: rtl/test_pattern_gen_axis_pixel_calc.sv
// Combinational pixel value for a given pattern mode and raster position.
module tpg_pixel_calc
  import tpg_pkg::*;
#(
  parameter  int unsigned WIDTH       = 64,
  parameter  int unsigned HEIGHT      = 64,
  parameter  int unsigned CH_BITWIDTH = 8,
  parameter  int unsigned CHECK_LOG2  = 3,
  localparam int unsigned XW          = $clog2(WIDTH),
  localparam int unsigned YW          = $clog2(HEIGHT),
  localparam int unsigned PW          = 3 * CH_BITWIDTH
) (
  input  logic [2:0]    mode,
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic [2:0]    bar,
  input  logic [PW-1:0] solid,
  output logic [PW-1:0] pixel_c
);

  logic left;
  logic top;
  logic chk;

  assign left = (x < XW'(WIDTH / 2));
  assign top  = (y < YW'(HEIGHT / 2));
  assign chk  = 1'((32'(x) >> CHECK_LOG2) ^ (32'(y) >> CHECK_LOG2));

  // Pattern select; unknown modes fall back to the quadrant pattern
  always_comb begin
    pixel_c = '0;
    case (mode)
      MODE_BARS:  pixel_c = PW'(code_to_pixel(3'd7 - bar, CH_BITWIDTH));
      MODE_GRAD:  pixel_c = {3{CH_BITWIDTH'(x)}};
      MODE_CHECK: pixel_c = PW'(code_to_pixel(chk ? CODE_WHITE : CODE_BLACK, CH_BITWIDTH));
      MODE_SOLID: pixel_c = solid;
      default: begin
        if (left) pixel_c = PW'(code_to_pixel(top ? CODE_RED : CODE_GREEN, CH_BITWIDTH));
        else      pixel_c = PW'(code_to_pixel(top ? CODE_BLUE : CODE_WHITE, CH_BITWIDTH));
      end
    endcase
  end

endmodule

// File: rtl/test_pattern_gen_axis.sv
// AXI4-Stream video test-pattern source: FSM, raster counters and output register.
module test_pattern_gen_axis
  import tpg_pkg::*;
#(
  parameter int unsigned WIDTH         = 64,
  parameter int unsigned HEIGHT        = 64,
  parameter int unsigned CH_BITWIDTH   = 8,
  parameter int unsigned CHECK_LOG2    = 3,
  parameter int unsigned FCNT_BITWIDTH = 16
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       i_start,
  input  logic                       i_stop,
  input  logic [2:0]                 i_mode,
  input  logic                       i_continuous,
  input  logic [3*CH_BITWIDTH-1:0]   i_solid_color,
  output logic [3*CH_BITWIDTH-1:0]   o_axis_tdata,
  output logic                       o_axis_tvalid,
  input  logic                       i_axis_tready,
  output logic                       o_axis_tlast,
  output logic                       o_axis_tuser,
  output logic                       o_busy,
  output logic                       o_frame_done,
  output logic [FCNT_BITWIDTH-1:0]   o_frame_count
);

  localparam int unsigned XW  = $clog2(WIDTH);
  localparam int unsigned YW  = $clog2(HEIGHT);
  localparam int unsigned XW1 = XW + 1;
  localparam int unsigned PW  = 3 * CH_BITWIDTH;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [2:0]      bar_q, bar_d;
  logic [2:0]      mode_q, mode_sel;
  logic [PW-1:0]   solid_q, solid_sel;
  logic            cont_q;
  logic            stop_q;
  logic            load;
  logic            frame_start;
  logic            handshake;
  logic            last_pix;
  logic [PW-1:0]   pixel_c;

  // First x of the bar following bar k: floor((k+1)*WIDTH/8)
  function automatic logic [XW1-1:0] bar_end(input logic [2:0] k);
    return XW1'(((32'(k) + 32'd1) * WIDTH) >> 3);
  endfunction

  assign handshake = o_axis_tvalid & i_axis_tready;
  assign last_pix  = (x_q == XW'(WIDTH - 1)) && (y_q == YW'(HEIGHT - 1));
  assign mode_sel  = frame_start ? i_mode : mode_q;
  assign solid_sel = frame_start ? i_solid_color : solid_q;

  // Next state, next raster position and whether a new pixel is presented
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    bar_d       = bar_q;
    load        = 1'b0;
    frame_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d     = ST_RUN;
          frame_start = 1'b1;
          load        = 1'b1;
          x_d         = '0;
          y_d         = '0;
          bar_d       = '0;
        end
      end
      ST_RUN: begin
        if (handshake) begin
          if (x_q == XW'(WIDTH - 1)) begin
            x_d   = '0;
            bar_d = '0;
            if (y_q == YW'(HEIGHT - 1)) begin
              y_d = '0;
              if (!cont_q || stop_q || i_stop) begin
                state_d = ST_IDLE;
              end else begin
                frame_start = 1'b1;
                load        = 1'b1;
              end
            end else begin
              y_d  = y_q + 1'b1;
              load = 1'b1;
            end
          end else begin
            x_d  = x_q + 1'b1;
            load = 1'b1;
            if (({1'b0, x_q} + 1'b1) == bar_end(bar_q)) bar_d = bar_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  tpg_pixel_calc #(
    .WIDTH       (WIDTH),
    .HEIGHT      (HEIGHT),
    .CH_BITWIDTH (CH_BITWIDTH),
    .CHECK_LOG2  (CHECK_LOG2)
  ) u_pixel_calc (
    .mode    (mode_sel),
    .x       (x_d),
    .y       (y_d),
    .bar     (bar_d),
    .solid   (solid_sel),
    .pixel_c (pixel_c)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!n_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Raster counters and per-frame latched settings
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      x_q     <= '0;
      y_q     <= '0;
      bar_q   <= '0;
      mode_q  <= '0;
      solid_q <= '0;
      cont_q  <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      bar_q <= bar_d;
      if (frame_start) begin
        mode_q  <= i_mode;
        solid_q <= i_solid_color;
      end
      if (state_q == ST_IDLE && i_start) cont_q <= i_continuous;
      if (state_q == ST_RUN && state_d == ST_IDLE) stop_q <= 1'b0;
      else if (state_q == ST_RUN && i_stop)        stop_q <= 1'b1;
    end
  end

  // Registered stream and status outputs; held while stalled
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      o_axis_tdata  <= '0;
      o_axis_tvalid <= 1'b0;
      o_axis_tlast  <= 1'b0;
      o_axis_tuser  <= 1'b0;
      o_busy        <= 1'b0;
      o_frame_done  <= 1'b0;
      o_frame_count <= '0;
    end else begin
      o_busy       <= (state_d == ST_RUN);
      o_frame_done <= handshake & last_pix;
      if (handshake & last_pix) o_frame_count <= o_frame_count + 1'b1;
      if (load) begin
        o_axis_tdata  <= pixel_c;
        o_axis_tvalid <= 1'b1;
        o_axis_tlast  <= (x_d == XW'(WIDTH - 1));
        o_axis_tuser  <= (x_d == '0) && (y_d == '0);
      end else if (handshake) begin
        o_axis_tdata  <= '0;
        o_axis_tvalid <= 1'b0;
        o_axis_tlast  <= 1'b0;
        o_axis_tuser  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_test_pattern_gen_axis.sv
// Self-checking bench for test_pattern_gen_axis against a raster-level reference model.
module tb_test_pattern_gen_axis;

  localparam int unsigned W  = 16;
  localparam int unsigned H  = 16;
  localparam int unsigned CH = 8;
  localparam int unsigned CL = 3;
  localparam int unsigned FB = 2;
  localparam int unsigned PW = 3 * CH;

  logic          clk;
  logic          n_rst;
  logic          i_start;
  logic          i_stop;
  logic [2:0]    i_mode;
  logic          i_continuous;
  logic [PW-1:0] i_solid_color;
  logic [PW-1:0] o_axis_tdata;
  logic          o_axis_tvalid;
  logic          i_axis_tready;
  logic          o_axis_tlast;
  logic          o_axis_tuser;
  logic          o_busy;
  logic          o_frame_done;
  logic [FB-1:0] o_frame_count;

  test_pattern_gen_axis #(
    .WIDTH(W), .HEIGHT(H), .CH_BITWIDTH(CH), .CHECK_LOG2(CL), .FCNT_BITWIDTH(FB)
  ) dut (
    .clk(clk), .n_rst(n_rst), .i_start(i_start), .i_stop(i_stop), .i_mode(i_mode),
    .i_continuous(i_continuous), .i_solid_color(i_solid_color),
    .o_axis_tdata(o_axis_tdata), .o_axis_tvalid(o_axis_tvalid), .i_axis_tready(i_axis_tready),
    .o_axis_tlast(o_axis_tlast), .o_axis_tuser(o_axis_tuser), .o_busy(o_busy),
    .o_frame_done(o_frame_done), .o_frame_count(o_frame_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference pixel straight from the pattern definitions
  function automatic logic [23:0] exp_pix(input int mode, input logic [23:0] solid,
                                          input int x, input int y);
    int code;
    code = 0;
    case (mode)
      1: begin
        int k;
        k = 0;
        for (int b = 0; b < 8; b++) if (x >= (b * int'(W)) / 8) k = b;
        code = 7 - k;
      end
      2: return {3{8'(x % 256)}};
      3: code = ((((x >> CL) ^ (y >> CL)) & 1) != 0) ? 7 : 0;
      4: return solid;
      default: begin
        if (x < int'(W) / 2) code = (y < int'(H) / 2) ? 4 : 2;
        else                 code = (y < int'(H) / 2) ? 1 : 7;
      end
    endcase
    return {((code & 4) != 0) ? 8'hFF : 8'h00,
            ((code & 2) != 0) ? 8'hFF : 8'h00,
            ((code & 1) != 0) ? 8'hFF : 8'h00};
  endfunction

  // Model state
  bit          m_ready = 1'b0;
  bit          m_active, m_cont, m_stop, m_done;
  int          mx, my, m_mode, m_count;
  logic [23:0] m_solid;
  bit          stall_prev;
  logic [23:0] prev_data;
  logic        prev_last, prev_user;
  bit          rnd_ready = 1'b0;

  typedef struct {
    logic [23:0] data;
    logic        last;
    logic        user;
  } beat_t;
  beat_t beats[$];

  function automatic logic [23:0] bdata(input int i);
    if (i < beats.size()) return beats[i].data;
    return 'x;
  endfunction
  function automatic logic blast(input int i);
    if (i < beats.size()) return beats[i].last;
    return 1'bx;
  endfunction
  function automatic logic buser(input int i);
    if (i < beats.size()) return beats[i].user;
    return 1'bx;
  endfunction

  // Reference model: raster position of the pixel on the bus, advanced per handshake
  initial forever begin
    @(posedge clk);
    m_done = 1'b0;
    if (!n_rst) begin
      m_ready = 1'b1; m_active = 1'b0; m_cont = 1'b0; m_stop = 1'b0;
      mx = 0; my = 0; m_count = 0; stall_prev = 1'b0;
    end else if (m_ready) begin
      if (!m_active) begin
        if (i_start) begin
          m_active = 1'b1; mx = 0; my = 0; m_stop = 1'b0;
          m_mode = int'(i_mode); m_solid = i_solid_color; m_cont = i_continuous;
        end
      end else begin
        if (i_stop) m_stop = 1'b1;
        if (i_axis_tready) begin
          mx++;
          if (mx == int'(W)) begin
            mx = 0; my++;
            if (my == int'(H)) begin
              my = 0; m_done = 1'b1; m_count++;
              if (m_cont && !m_stop) begin
                m_mode = int'(i_mode); m_solid = i_solid_color;
              end else begin
                m_active = 1'b0; m_stop = 1'b0;
              end
            end
          end
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge
  initial forever begin
    @(negedge clk);
    if (m_ready) begin
      check("tvalid", 64'(o_axis_tvalid), 64'(m_active));
      check("busy", 64'(o_busy), 64'(m_active));
      check("frame_done", 64'(o_frame_done), 64'(m_done));
      check("frame_count", 64'(o_frame_count), 64'(m_count % (1 << FB)));
      if (m_active) begin
        check("tdata", 64'(o_axis_tdata), 64'(exp_pix(m_mode, m_solid, mx, my)));
        check("tlast", 64'(o_axis_tlast), 64'(mx == int'(W) - 1));
        check("tuser", 64'(o_axis_tuser), 64'(mx == 0 && my == 0));
      end else begin
        check("tlast_idle", 64'(o_axis_tlast), 64'(0));
        check("tuser_idle", 64'(o_axis_tuser), 64'(0));
      end
      if (stall_prev) begin
        check("hold_tdata", 64'(o_axis_tdata), 64'(prev_data));
        check("hold_tlast", 64'(o_axis_tlast), 64'(prev_last));
        check("hold_tuser", 64'(o_axis_tuser), 64'(prev_user));
      end
      stall_prev = o_axis_tvalid && !i_axis_tready && n_rst;
      prev_data  = o_axis_tdata;
      prev_last  = o_axis_tlast;
      prev_user  = o_axis_tuser;
      if (o_axis_tvalid && i_axis_tready)
        beats.push_back('{data: o_axis_tdata, last: o_axis_tlast, user: o_axis_tuser});
    end
  end

  // Ready driver: constant 1 or 50% random
  initial begin
    i_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      i_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [2:0] mode, input logic cont, input logic [23:0] solid);
    i_mode = mode; i_continuous = cont; i_solid_color = solid; i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      @(negedge clk);
      if (o_frame_done) seen = 1'b1;
    end
    check(name, 64'(seen), 64'(1));
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    tick(); tick();
    n_rst = 1'b1;
    tick();
  endtask

  logic [23:0] bars [8];
  int          cnts [5];
  int          exp_cnt [5];

  initial begin
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'hFF00FF, 24'hFF0000,
             24'h00FFFF, 24'h00FF00, 24'h0000FF, 24'h000000};
    exp_cnt = '{1, 2, 3, 0, 1};
    n_rst = 1'b0; i_start = 1'b0; i_stop = 1'b0; i_mode = 3'd0;
    i_continuous = 1'b0; i_solid_color = '0;
    tick(); tick(); tick();
    @(negedge clk);
    check("rst_tvalid", 64'(o_axis_tvalid), 64'(0));
    check("rst_tdata", 64'(o_axis_tdata), 64'(0));
    check("rst_busy", 64'(o_busy), 64'(0));
    check("rst_count", 64'(o_frame_count), 64'(0));
    n_rst = 1'b1;
    tick();

    // Quadrant, full-rate
    beats.delete();
    start_frame(3'd0, 1'b0, 24'h0);
    wait_done(1000, "quad_done");
    check("quad_beats", 64'(beats.size()), 64'(256));
    check("quad_b0", 64'(bdata(0)), 64'(24'hFF0000));
    check("quad_b0_user", 64'(buser(0)), 64'(1));
    check("quad_b7", 64'(bdata(7)), 64'(24'hFF0000));
    check("quad_b8", 64'(bdata(8)), 64'(24'h0000FF));
    check("quad_b15", 64'(bdata(15)), 64'(24'h0000FF));
    check("quad_b15_last", 64'(blast(15)), 64'(1));
    check("quad_b128", 64'(bdata(128)), 64'(24'h00FF00));
    check("quad_b255", 64'(bdata(255)), 64'(24'hFFFFFF));
    @(negedge clk);
    check("quad_busy_low", 64'(o_busy), 64'(0));
    check("quad_count", 64'(o_frame_count), 64'(1));

    // Colour bars
    beats.delete();
    start_frame(3'd1, 1'b0, 24'h0);
    wait_done(1000, "bars_done");
    for (int i = 0; i < 16; i++) check("bars_pix", 64'(bdata(i)), 64'(bars[i / 2]));
    check("bars_b14_last", 64'(blast(14)), 64'(0));
    check("bars_b15_last", 64'(blast(15)), 64'(1));
    check("bars_b31_last", 64'(blast(31)), 64'(1));

    // Checkerboard under random backpressure
    beats.delete();
    rnd_ready = 1'b1;
    start_frame(3'd3, 1'b0, 24'h0);
    wait_done(4000, "check_done");
    rnd_ready = 1'b0;
    check("check_beats", 64'(beats.size()), 64'(256));
    check("check_b0", 64'(bdata(0)), 64'(24'h000000));
    check("check_b7", 64'(bdata(7)), 64'(24'h000000));
    check("check_b8", 64'(bdata(8)), 64'(24'hFFFFFF));
    check("check_b128", 64'(bdata(128)), 64'(24'hFFFFFF));
    check("check_b136", 64'(bdata(136)), 64'(24'h000000));

    // Reset mid-frame aborts, then restart from (0,0)
    beats.delete();
    start_frame(3'd0, 1'b0, 24'h0);
    for (int i = 0; i < 200 && beats.size() < 10; i++) @(negedge clk);
    check("abort_reach", 64'(beats.size() >= 10), 64'(1));
    tick();
    n_rst = 1'b0;
    tick();
    @(negedge clk);
    check("abort_tvalid", 64'(o_axis_tvalid), 64'(0));
    check("abort_tdata", 64'(o_axis_tdata), 64'(0));
    check("abort_tlast", 64'(o_axis_tlast), 64'(0));
    check("abort_tuser", 64'(o_axis_tuser), 64'(0));
    check("abort_busy", 64'(o_busy), 64'(0));
    check("abort_count", 64'(o_frame_count), 64'(0));
    n_rst = 1'b1;
    tick();
    start_frame(3'd0, 1'b0, 24'h0);
    @(negedge clk);
    check("restart_tuser", 64'(o_axis_tuser), 64'(1));
    check("restart_tdata", 64'(o_axis_tdata), 64'(24'hFF0000));
    wait_done(1000, "restart_done");

    // Continuous solid then gradient, stop during frame 2
    do_reset();
    beats.delete();
    start_frame(3'd4, 1'b1, 24'h123456);
    repeat (50) tick();
    i_mode = 3'd2;
    i_solid_color = 24'hABCDEF;
    wait_done(1000, "cont_f1");
    repeat (20) tick();
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    wait_done(1000, "cont_f2");
    @(negedge clk);
    check("cont_busy_low", 64'(o_busy), 64'(0));
    check("cont_count", 64'(o_frame_count), 64'(2));
    check("cont_beats", 64'(beats.size()), 64'(512));
    check("cont_b0", 64'(bdata(0)), 64'(24'h123456));
    check("cont_b255", 64'(bdata(255)), 64'(24'h123456));
    check("cont_b256", 64'(bdata(256)), 64'(24'h000000));
    check("cont_b256_user", 64'(buser(256)), 64'(1));
    check("cont_b257", 64'(bdata(257)), 64'(24'h010101));
    check("cont_b511", 64'(bdata(511)), 64'(24'h0F0F0F));

    // Frame counter wrap over five continuous frames, modes 5-7 and bars mixed
    do_reset();
    rnd_ready = 1'b1;
    start_frame(3'd5, 1'b1, 24'h0);
    for (int f = 0; f < 5; f++) begin
      if (f == 1) i_mode = 3'd7;
      if (f == 2) i_mode = 3'd1;
      wait_done(4000, "wrap_done");
      cnts[f] = int'(o_frame_count);
      if (f == 3) begin
        repeat (5) tick();
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
      end
    end
    rnd_ready = 1'b0;
    for (int f = 0; f < 5; f++) check("wrap_count", 64'(cnts[f]), 64'(exp_cnt[f]));
    @(negedge clk);
    check("wrap_busy_low", 64'(o_busy), 64'(0));
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
